can_rx: RTL and testbench
=========================

# can_rx

CAN 2.0A base-frame receiver: samples one bus bit per `clk` on `bit_in` and removes stuff bits. Reassembles ID, RTR, DLC and data, checks CRC-15 and frame form, and presents the frame on a one-cycle valid strobe. It is the receive-side counterpart of the bit-serial transmit controller and uses the same one-bit-per-clock bus model, with no bit-timing or synchronisation segments.

## Interface
Parameters:
- none; all field widths and constants come from `can_pkg`.

Ports:
- `clk` in 1: single clock; `bit_in` is sampled on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `bit_in` in 1: serial bus bit; 0 is dominant, 1 is recessive.
- `RX_ID` out 11: received identifier.
- `RX_RTR` out 1: remote-request bit.
- `RX_DLC` out 4: raw DLC as received.
- `RX_DATA` out 8 bits × [7:0], unpacked array: data bytes, byte 0 first; bytes not received read 0.
- `RX_VALID` out 1: one-cycle pulse when a good frame completes.
- `RX_BUSY` out 1: high from the SOF sample until the frame ends or an error occurs.
- `RX_ERR` out 1: one-cycle pulse when an error is detected.
- `RX_ERR_CODE` out 2: error cause; 01 stuff, 10 CRC, 11 form. Holds until the next SOF.
- `ack_out` out 1: ACK drive; 0 means dominant ACK.

## Operation
- State machine: IDLE → ID (11 bits) → CTRL (RTR, IDE, r0, DLC[3:0]) → DATA (8·N bits) → CRC (15 bits) → CRC_DEL → ACK → ACK_DEL → EOF (7 bits) → IDLE. An ERR_WAIT state is entered from any state on error.
- SOF:
  - IDLE moves to ID when a dominant bit is sampled.
  - That SOF bit feeds the destuffer and the CRC.
- Data length:
  - N = min(DLC, 8).
  - N = 0 when RTR = 1 or DLC = 0; DATA is skipped and the state goes straight to CRC.
- Destuffing, from SOF through the last CRC bit:
  - Track the run length of equal bits.
  - After 5 equal bits, the next bit is a stuff bit.
  - If the stuff bit is the complement: discard it and reset the run length to 1.
  - If it equals the previous bit: stuff error.
  - Stuff bits are never shifted into fields or into the CRC.
  - No destuffing is done from CRC_DEL onward.
- CRC:
  - CRC-15, polynomial 0x4599, initial value 0.
  - Runs over the destuffed bits from SOF through the last data bit.
  - In CRC state, the received 15 bits are compared with the computed value; a mismatch is recorded, not flagged yet.
- Form checks, all raising a form error:
  - IDE = 1, since extended frames are not supported.
  - CRC_DEL = 0.
  - ACK_DEL = 0.
  - Any EOF bit = 0.
- The ACK slot value is not checked.
- CRC error is flagged when ACK_DEL is sampled, if a mismatch was recorded; the form check on ACK_DEL takes priority.
- Error handling:
  - Pulse `RX_ERR`, load `RX_ERR_CODE`, drop `RX_BUSY`, enter ERR_WAIT.
  - ERR_WAIT returns to IDLE after 7 consecutive recessive samples; any dominant sample restarts the count.
- Good frame: `RX_ID`, `RX_RTR`, `RX_DLC` and `RX_DATA` update together with the `RX_VALID` pulse and hold until the next valid frame. Partial frames never modify them.

## Timing
- Reset values:
  - `RX_ID`, `RX_RTR`, `RX_DLC`, `RX_DATA`, `RX_VALID`, `RX_ERR`, `RX_ERR_CODE`, `RX_BUSY` all 0.
  - `ack_out` = 1.
  - State IDLE.
- `RX_BUSY` rises on the edge after the SOF sample.
- `RX_VALID` pulses on the edge after the 7th EOF bit is sampled, for one cycle; `RX_BUSY` falls on the same edge.
- A dominant bit sampled in the cycle right after EOF completion is treated as a new SOF; no intermission is required.
- `RX_ERR` pulses on the edge after the offending bit is sampled.
- `ack_out`:
  - Goes low on the edge that samples CRC_DEL, provided the CRC matched and CRC_DEL = 1.
  - Returns high on the following edge, so it is low for exactly the ACK-slot bit period.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded with no `RX_ERR`.

## Configuration
- `CAN_RX_ACK_EN` defined: `ack_out` behaves as above.
- `CAN_RX_ACK_EN` undefined: `ack_out` is tied to 1 and the ACK logic is removed. CRC checking and error reporting are unchanged.

## Structure
- `can_pkg` holds:
  - the state enum `can_rx_state_t`;
  - `CAN_CRC_POLY` = 15'h4599;
  - the widths `CAN_ID_W` = 11 and `CAN_DLC_W` = 4;
  - `CAN_MAX_BYTES` = 8 and `CAN_EOF_LEN` = 7;
  - the error-code constants.
- Sub-module `can_crc15`: clear, enable, and data-bit inputs; 15-bit CRC output. It is shared with the transmitter.

## Test plan
- Good frame: ID 0x150, DLC 6, data 55 32 18 10 01 05, correctly stuffed and CRC'd → one `RX_VALID` pulse, `RX_ID` = 0x150, `RX_DLC` = 6, bytes 6–7 = 0, `ack_out` low for the ACK slot only, `RX_ERR` never pulses.
- Same frame with one CRC bit flipped → `RX_ERR` pulses at ACK_DEL with code 10, no `RX_VALID`, `ack_out` stays 1, outputs keep the previous frame's values.
- ID 0x000 sent with the first stuff bit omitted (six dominant bits) → stuff error, code 01, at the 6th bit. After 7 recessive bits a following good frame is received.
- DLC = 12 frame → 8 bytes captured, `RX_DLC` = 12. RTR = 1 with DLC = 4 → no data bits expected, `RX_VALID` pulses, `RX_DATA` all 0.
- EOF bit 4 forced dominant → form error, code 11. With IDE = 1 → form error detected at the IDE bit.
- Reset pulsed low mid-DATA → all outputs return to reset values, no `RX_ERR`. A following good frame decodes correctly.

Source files
------------

// File: rtl/can_pkg.sv
// Shared definitions for the CAN 2.0A bit-serial controllers: receiver state
// encoding, CRC polynomial, field widths and error codes.
package can_pkg;

  localparam int CAN_ID_W      = 11;
  localparam int CAN_DLC_W     = 4;
  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_EOF_LEN   = 7;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  localparam logic [1:0] CAN_ERR_NONE  = 2'b00;
  localparam logic [1:0] CAN_ERR_STUFF = 2'b01;
  localparam logic [1:0] CAN_ERR_CRC   = 2'b10;
  localparam logic [1:0] CAN_ERR_FORM  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    CTRL,
    DATA,
    CRC,
    CRC_DEL,
    ACK,
    ACK_DEL,
    EOF,
    ERR_WAIT
  } can_rx_state_t;

  // Payload length in bytes: remote frames carry none, DLC above 8 saturates.
  function automatic logic [3:0] can_n_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// CAN CRC-15 accumulator, one bit per enabled clock. Asserting clr together
// with en restarts the sequence and folds din in as its first bit.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] base;
  logic [14:0] stepped;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    base    = clr ? '0 : crc;
    stepped = {base[13:0], 1'b0} ^ ((din ^ base[14]) ? CAN_CRC_POLY : 15'h0000);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     crc <= '0;
    else if (en)  crc <= stepped;
    else if (clr) crc <= '0;
  end

endmodule

// File: rtl/can_rx.sv
// CAN 2.0A base-frame receiver, one bus bit per clk: destuffing, field
// reassembly, CRC-15 and form checks. Define CAN_RX_ACK_EN to drive ack_out.
module can_rx
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  output logic [CAN_ID_W-1:0]  RX_ID,
  output logic                 RX_RTR,
  output logic [CAN_DLC_W-1:0] RX_DLC,
  output logic [7:0]           RX_DATA [CAN_MAX_BYTES],
  output logic                 RX_VALID,
  output logic                 RX_BUSY,
  output logic                 RX_ERR,
  output logic [1:0]           RX_ERR_CODE,
  output logic                 ack_out
);

  can_rx_state_t state, state_nxt;

  logic [5:0]           bit_cnt;
  logic                 last_bit;
  logic [2:0]           run_len, run_len_nxt;
  logic                 sof, in_stuff_zone, is_stuff, take;
  logic [CAN_ID_W-1:0]  id_sr;
  logic                 rtr_r;
  logic [CAN_DLC_W-1:0] dlc_r, dlc_full;
  logic [3:0]           n_bytes, n_bytes_now;
  logic                 data_last;
  logic [7:0]           data_buf [CAN_MAX_BYTES];
  logic [13:0]          crc_sr;
  logic [14:0]          crc_calc, crc_rx_full;
  logic                 crc_bad;
  logic                 crc_en;
  logic [1:0]           err_code;
  logic                 frame_done;

  assign sof           = (state == IDLE) && !bit_in;
  assign in_stuff_zone = state inside {ID, CTRL, DATA, CRC};
  assign is_stuff      = in_stuff_zone && (run_len == 3'd5);
  assign take          = in_stuff_zone && !is_stuff;
  assign run_len_nxt   = (!is_stuff && bit_in == last_bit) ? run_len + 3'd1 : 3'd1;

  assign crc_en      = sof || (take && (state inside {ID, CTRL, DATA}));
  assign dlc_full    = {dlc_r[CAN_DLC_W-2:0], bit_in};
  assign n_bytes_now = can_n_bytes(rtr_r, dlc_full);
  assign n_bytes     = can_n_bytes(rtr_r, dlc_r);
  assign data_last   = ({1'b0, bit_cnt[5:3]} + 4'd1 == n_bytes) && (bit_cnt[2:0] == 3'b111);
  assign crc_rx_full = {crc_sr, bit_in};

  can_crc15 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (sof),
    .en  (crc_en),
    .din (bit_in),
    .crc (crc_calc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Error and completion decode for the bit being sampled this cycle.
  always_comb begin
    err_code   = CAN_ERR_NONE;
    frame_done = 1'b0;
    if (is_stuff && bit_in == last_bit) begin
      err_code = CAN_ERR_STUFF;
    end else begin
      case (state)
        CTRL:         if (take && bit_cnt == 6'd1 && bit_in) err_code = CAN_ERR_FORM;
        CRC_DEL, EOF: if (!bit_in) err_code = CAN_ERR_FORM;
        ACK_DEL: begin
          if (!bit_in)      err_code = CAN_ERR_FORM;
          else if (crc_bad) err_code = CAN_ERR_CRC;
        end
        default: ;
      endcase
    end
    if (state == EOF && bit_in && bit_cnt == 6'(CAN_EOF_LEN - 1)) frame_done = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (err_code != CAN_ERR_NONE) begin
      state_nxt = ERR_WAIT;
    end else begin
      case (state)
        IDLE:     if (!bit_in) state_nxt = ID;
        ID:       if (take && bit_cnt == 6'(CAN_ID_W - 1)) state_nxt = CTRL;
        CTRL:     if (take && bit_cnt == 6'd6) state_nxt = (n_bytes_now == 4'd0) ? CRC : DATA;
        DATA:     if (take && data_last) state_nxt = CRC;
        // After the 15th CRC bit a trailing stuff bit may still be owed.
        CRC: begin
          if (is_stuff) begin
            if (bit_cnt == 6'd15) state_nxt = CRC_DEL;
          end else if (bit_cnt == 6'd14 && run_len_nxt != 3'd5) begin
            state_nxt = CRC_DEL;
          end
        end
        CRC_DEL:  state_nxt = ACK;
        ACK:      state_nxt = ACK_DEL;
        ACK_DEL:  state_nxt = EOF;
        EOF:      if (frame_done) state_nxt = IDLE;
        ERR_WAIT: if (bit_in && bit_cnt == 6'(CAN_EOF_LEN - 1)) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      last_bit    <= 1'b1;
      run_len     <= '0;
      id_sr       <= '0;
      rtr_r       <= 1'b0;
      dlc_r       <= '0;
      crc_sr      <= '0;
      crc_bad     <= 1'b0;
      RX_ID       <= '0;
      RX_RTR      <= 1'b0;
      RX_DLC      <= '0;
      RX_VALID    <= 1'b0;
      RX_BUSY     <= 1'b0;
      RX_ERR      <= 1'b0;
      RX_ERR_CODE <= CAN_ERR_NONE;
      // NOTE: the byte buffers are reset because unreceived bytes must read 0.
      for (int i = 0; i < CAN_MAX_BYTES; i++) begin
        data_buf[i] <= '0;
        RX_DATA[i]  <= '0;
      end
    end else begin
      if (state_nxt != state)                                bit_cnt <= '0;
      else if (take || state == EOF || (state == ERR_WAIT && bit_in)) bit_cnt <= bit_cnt + 6'd1;
      else if (state == ERR_WAIT)                            bit_cnt <= '0;

      if (sof) begin
        last_bit <= 1'b0;
        run_len  <= 3'd1;
        crc_bad  <= 1'b0;
        for (int i = 0; i < CAN_MAX_BYTES; i++) data_buf[i] <= '0;
      end else if (in_stuff_zone) begin
        last_bit <= bit_in;
        run_len  <= run_len_nxt;
      end

      if (take) begin
        case (state)
          ID:   id_sr <= {id_sr[CAN_ID_W-2:0], bit_in};
          CTRL: begin
            if (bit_cnt == 6'd0)  rtr_r <= bit_in;
            if (bit_cnt >= 6'd3)  dlc_r <= dlc_full;
          end
          DATA: data_buf[bit_cnt[5:3]] <= {data_buf[bit_cnt[5:3]][6:0], bit_in};
          CRC: begin
            crc_sr <= crc_rx_full[13:0];
            if (bit_cnt == 6'd14) crc_bad <= (crc_rx_full != crc_calc);
          end
          default: ;
        endcase
      end

      RX_VALID <= frame_done;
      RX_ERR   <= (err_code != CAN_ERR_NONE);
      RX_BUSY  <= !(state_nxt inside {IDLE, ERR_WAIT});
      if (err_code != CAN_ERR_NONE) RX_ERR_CODE <= err_code;
      else if (sof)                 RX_ERR_CODE <= CAN_ERR_NONE;

      if (frame_done) begin
        RX_ID   <= id_sr;
        RX_RTR  <= rtr_r;
        RX_DLC  <= dlc_r;
        RX_DATA <= data_buf;
      end
    end
  end

`ifdef CAN_RX_ACK_EN
  // Dominant for exactly the ACK slot that follows a good CRC and delimiter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_out <= 1'b1;
    else      ack_out <= !(state == CRC_DEL && bit_in && !crc_bad);
  end
`else
  assign ack_out = 1'b1;
`endif

endmodule

// File: tb/tb_can_rx.sv
// Scoreboard bench for can_rx: a bit-level transmitter model builds stuffed,
// CRC'd frames; expected frames/errors are queued and matched by a monitor.
module tb_can_rx;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic [10:0] RX_ID;
  logic       RX_RTR;
  logic [3:0] RX_DLC;
  logic [7:0] RX_DATA [8];
  logic       RX_VALID, RX_BUSY, RX_ERR;
  logic [1:0] RX_ERR_CODE;
  logic       ack_out;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  logic frame_q[$];
  int   ack_idx;
  int   n_vec;
  int   n_bad;

  can_rx dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .RX_ID       (RX_ID),
    .RX_RTR      (RX_RTR),
    .RX_DLC      (RX_DLC),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .RX_BUSY     (RX_BUSY),
    .RX_ERR      (RX_ERR),
    .RX_ERR_CODE (RX_ERR_CODE),
    .ack_out     (ack_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rx_data_packed();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = RX_DATA[i];
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_id"},    64'(RX_ID),       64'd0);
    check({tag, "_rtr"},   64'(RX_RTR),      64'd0);
    check({tag, "_dlc"},   64'(RX_DLC),      64'd0);
    check({tag, "_data"},  rx_data_packed(), 64'd0);
    check({tag, "_valid"}, 64'(RX_VALID),    64'd0);
    check({tag, "_err"},   64'(RX_ERR),      64'd0);
    check({tag, "_code"},  64'(RX_ERR_CODE), 64'd0);
    check({tag, "_busy"},  64'(RX_BUSY),     64'd0);
    check({tag, "_ack"},   64'(ack_out),     64'd1);
  endtask

  task automatic expect_frame(input logic [10:0] id, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data);
    exp_t e;
    e = '0;
    e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.code   = code;
    sb_q.push_back(e);
  endtask

  // Transmitter model: raw fields, CRC-15, bit stuffing through the CRC, then
  // recessive CRC_DEL, ACK, ACK_DEL and 7 EOF bits.
  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic flip_crc);
    logic        raw[$];
    logic [14:0] crc;
    logic        fb, last;
    int          n, run;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < n * 8; i++) raw.push_back(data[63-i]);
    crc = '0;
    foreach (raw[k]) begin
      fb  = raw[k] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    if (flip_crc) crc[6] = ~crc[6];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    frame_q.delete();
    last = 1'b1;
    run  = 0;
    foreach (raw[k]) begin
      frame_q.push_back(raw[k]);
      if (run > 0 && raw[k] == last) run++;
      else begin
        run  = 1;
        last = raw[k];
      end
      if (run == 5) begin
        frame_q.push_back(~raw[k]);
        last = ~raw[k];
        run  = 1;
      end
    end
    ack_idx = frame_q.size() + 1;
    repeat (10) frame_q.push_back(1'b1);
  endtask

  task automatic send_frame(input logic exp_ack_low, input int idle_n);
    logic ack_exp;
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_sof", 64'(RX_BUSY), 64'd1);
      if (i >= ack_idx - 1 && i <= ack_idx + 1) begin
        ack_exp = (i == ack_idx && exp_ack_low) ? 1'b0 : 1'b1;
`ifndef CAN_RX_ACK_EN
        ack_exp = 1'b1;
`endif
        check("ack_slot", 64'(ack_out), 64'(ack_exp));
      end
      bit_in = frame_q[i];
    end
    repeat (idle_n) begin
      @(negedge clk);
      bit_in = 1'b1;
    end
  endtask

  // Monitor: every VALID or ERR pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (RX_VALID || RX_ERR)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {62'd0, RX_VALID, RX_ERR}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_kind", {62'd0, RX_VALID, RX_ERR}, e.is_err ? 64'd1 : 64'd2);
          if (e.is_err) begin
            check("err_code", 64'(RX_ERR_CODE), 64'(e.code));
          end else begin
            check("rx_id",   64'(RX_ID),  64'(e.id));
            check("rx_rtr",  64'(RX_RTR), 64'(e.rtr));
            check("rx_dlc",  64'(RX_DLC), 64'(e.dlc));
            check("rx_data", rx_data_packed(), e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame, 6 bytes.
    build_frame(11'h150, 1'b0, 1'b0, 4'd6, 64'h5532181001050000, 1'b0);
    expect_frame(11'h150, 1'b0, 4'd6, 64'h5532181001050000);
    send_frame(1'b1, 10);
    check("busy_after_frame", 64'(RX_BUSY), 64'd0);
    check("code_after_good",  64'(RX_ERR_CODE), 64'd0);

    // Same frame with a corrupted CRC bit.
    build_frame(11'h150, 1'b0, 1'b0, 4'd6, 64'h5532181001050000, 1'b1);
    expect_err(2'b10);
    send_frame(1'b0, 10);
    check("crc_err_keeps_id",   64'(RX_ID),  64'h150);
    check("crc_err_keeps_dlc",  64'(RX_DLC), 64'd6);
    check("crc_err_keeps_data", rx_data_packed(), 64'h5532181001050000);
    check("crc_err_code_holds", 64'(RX_ERR_CODE), 64'd2);

    // ID 0x000 with the first stuff bit missing: six dominant bits.
    expect_err(2'b01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bit_in = 1'b0;
    end
    @(posedge clk);
    #1;
    check("stuff_err_pulse", 64'(RX_ERR),  64'd1);
    check("stuff_busy_drop", 64'(RX_BUSY), 64'd0);
    repeat (10) begin
      @(negedge clk);
      bit_in = 1'b1;
    end

    build_frame(11'h2AB, 1'b0, 1'b0, 4'd2, 64'hA50F000000000000, 1'b0);
    expect_frame(11'h2AB, 1'b0, 4'd2, 64'hA50F000000000000);
    send_frame(1'b1, 10);

    // DLC 12 saturates at 8 bytes; next frame follows with no intermission.
    build_frame(11'h123, 1'b0, 1'b0, 4'd12, 64'h1122334455667788, 1'b0);
    expect_frame(11'h123, 1'b0, 4'd12, 64'h1122334455667788);
    send_frame(1'b1, 0);

    // Remote frame: DLC 4 but no data bits on the bus.
    build_frame(11'h3FF, 1'b1, 1'b0, 4'd4, 64'hDEADBEEFDEADBEEF, 1'b0);
    expect_frame(11'h3FF, 1'b1, 4'd4, 64'h0);
    send_frame(1'b1, 10);

    // EOF bit 4 dominant.
    build_frame(11'h150, 1'b0, 1'b0, 4'd6, 64'h5532181001050000, 1'b0);
    frame_q[ack_idx + 5] = 1'b0;
    expect_err(2'b11);
    send_frame(1'b1, 10);
    check("eof_err_keeps_id", 64'(RX_ID), 64'h3FF);

    // Extended-frame IDE bit.
    build_frame(11'h0F0, 1'b0, 1'b1, 4'd1, 64'h3C00000000000000, 1'b0);
    expect_err(2'b11);
    send_frame(1'b0, 10);

    // Reset pulsed in the middle of the DATA field.
    build_frame(11'h2AB, 1'b0, 1'b0, 4'd2, 64'hA50F000000000000, 1'b0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bit_in = frame_q[i];
    end
    @(negedge clk);
    rst    = 1'b0;
    bit_in = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    build_frame(11'h150, 1'b0, 1'b0, 4'd6, 64'h5532181001050000, 1'b0);
    expect_frame(11'h150, 1'b0, 4'd6, 64'h5532181001050000);
    send_frame(1'b1, 10);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
